// File: rtl/reg_pkg.sv
// Shared constants and FSM state type for the register bank and its burst reader.
package reg_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } reader_state_t;

endpackage

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register storage: synchronous write, combinational read, async clear.
module reg_bank
    import reg_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry storage; every entry returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/reg_burst_reader.sv
// Register bank with a burst read-out engine streaming consecutive entries over valid/ready.
//
// state  | meaning
// IDLE   | no burst; rd_start with rd_len != 0 loads beat 0
// STREAM | a beat is held in the output register until accepted
module reg_burst_reader
    import reg_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    output logic              rd_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    reader_state_t     state, state_nxt;
    logic [ADDR_W:0]   rem, rem_nxt;
    logic [WIDTH-1:0]  data_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              valid_nxt;
    logic              last_nxt;
    logic [ADDR_W-1:0] load_addr;
    logic [WIDTH-1:0]  bank_data;
    logic [WIDTH-1:0]  load_data;

    reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (load_addr),
        .rd_data (bank_data)
    );

    // Address of the beat that would be loaded this cycle: rd_base when idle, else the successor.
    assign load_addr = (state == IDLE) ? rd_base : out_addr + ADDR_ONE;

    // A same-cycle write to the loaded entry wins, so the beat carries the newest value.
    assign load_data = (wr_en && (wr_addr == load_addr)) ? wr_data : bank_data;

    // Next-state and output-register updates; everything holds unless a start or handshake occurs.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        data_nxt  = out_data;
        addr_nxt  = out_addr;
        valid_nxt = out_valid;
        last_nxt  = out_last;
        unique case (state)
            IDLE: begin
                if (rd_start && (rd_len != '0)) begin
                    state_nxt = STREAM;
                    data_nxt  = load_data;
                    addr_nxt  = load_addr;
                    rem_nxt   = rd_len - CNT_ONE;
                    valid_nxt = 1'b1;
                    last_nxt  = (rd_len == CNT_ONE);
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (rem != '0) begin
                        data_nxt = load_data;
                        addr_nxt = load_addr;
                        rem_nxt  = rem - CNT_ONE;
                        last_nxt = (rem == CNT_ONE);
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and output registers; rd_busy is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_busy   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            out_data  <= data_nxt;
            out_addr  <= addr_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
            rd_busy   <= (state_nxt == STREAM);
        end
    end

endmodule

// File: tb/tb_reg_burst_reader.sv
// Self-checking bench for reg_burst_reader: beat-indexed reference model plus directed and random bursts.
module tb_reg_burst_reader;
    import reg_pkg::*;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W:0]   rd_len;
    logic              rd_busy;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents plus the beat currently offered.
    logic [WIDTH-1:0]  mem_m [DEPTH];
    logic              exp_valid;
    logic              exp_last;
    logic [WIDTH-1:0]  exp_data;
    logic [ADDR_W-1:0] exp_addr;
    int                k;
    int                b_base;
    int                b_len;
    int                got_addr[$];
    int                got_data[$];

    reg_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_start  (rd_start),
        .rd_base   (rd_base),
        .rd_len    (rd_len),
        .rd_busy   (rd_busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;
        exp_addr  = '0;
        k = 0;
        b_base = 0;
        b_len = 0;
    endtask

    // Beat k of the current burst, snapshotted with the write that lands in the same cycle.
    task automatic model_load(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        int a;
        a = (b_base + k) % DEPTH;
        exp_addr = ADDR_W'(a);
        exp_data = (we && (int'(wa) == a)) ? wd : mem_m[a];
        exp_last = (k == b_len - 1);
        exp_valid = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, advance the model, compare at the next falling edge.
    task automatic cycle(input logic start, input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                         input logic ready, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [WIDTH-1:0] wd);
        rd_start  = start;
        rd_base   = base;
        rd_len    = len;
        out_ready = ready;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        if (exp_valid && ready) begin
            got_addr.push_back(int'(exp_addr));
            got_data.push_back(int'(exp_data));
            if (k == b_len - 1) begin
                exp_valid = 1'b0;
                exp_last  = 1'b0;
            end else begin
                k++;
                model_load(we, wa, wd);
            end
        end else if (!exp_valid && start && (len != 0)) begin
            b_base = int'(base);
            b_len  = int'(len);
            k = 0;
            model_load(we, wa, wd);
        end
        if (we) mem_m[wa] = wd;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, rd_busy, out_last} !== {exp_valid, exp_valid, exp_last}) begin
            errors++;
            $display("FAIL ctrl t=%0t valid/busy/last got %b%b%b expected %b%b%b", $time,
                     out_valid, rd_busy, out_last, exp_valid, exp_valid, exp_last);
        end
        checks++;
        if (out_data !== exp_data || out_addr !== exp_addr) begin
            errors++;
            $display("FAIL beat t=%0t data/addr got %h/%0d expected %h/%0d", $time,
                     out_data, out_addr, exp_data, exp_addr);
        end
    endtask

    task automatic idle_cycle(input logic ready);
        cycle(1'b0, '0, '0, ready, 1'b0, '0, '0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_valid; i++) idle_cycle(1'b1);
        checks++;
        if (exp_valid) begin
            errors++;
            $display("FAIL %s timeout got valid=%b expected 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {wr_en, rd_start, out_ready} = '0;
        wr_addr = '0; wr_data = '0; rd_base = '0; rd_len = '0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, rd_busy, out_last, out_data, out_addr} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %b%b%b %h %0d expected all 0",
                     out_valid, rd_busy, out_last, out_data, out_addr);
        end
        rst_n = 1'b1;
        idle_cycle(1'b1);
    endtask

    task automatic test_basic();
        got_addr.delete(); got_data.delete();
        cycle(1'b1, 3'd0, 4'd3, 1'b1, 1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency valid/last got %b%b expected 10", out_valid, out_last);
        end
        drain("basic");
        checks++;
        if (got_addr.size() != 3 || got_addr[0] != 0 || got_addr[1] != 1 || got_addr[2] != 2
            || got_data[0] != 0 || got_data[1] != 0 || got_data[2] != 0) begin
            errors++;
            $display("FAIL basic_beats got %0d beats expected 3 beats addr 0,1,2 data 0", got_addr.size());
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 3'd6, 4'd5);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 3'd7, 4'd5);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 3'd0, 4'd9);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 3'd1, 4'd9);
        got_addr.delete(); got_data.delete();
        cycle(1'b1, 3'd6, 4'd4, 1'b1, 1'b0, '0, '0);
        drain("wrap");
        checks++;
        if (got_addr.size() != 4 || got_addr[0] != 6 || got_addr[1] != 7 || got_addr[2] != 0
            || got_addr[3] != 1 || got_data[0] != 5 || got_data[1] != 5 || got_data[2] != 9
            || got_data[3] != 9) begin
            errors++;
            $display("FAIL wrap_beats got %0d beats expected addr 6,7,0,1 data 5,5,9,9", got_addr.size());
        end
    endtask

    task automatic test_stall();
        got_addr.delete(); got_data.delete();
        cycle(1'b1, 3'd2, 4'd3, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 3'd2, 4'hF);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (out_data !== 4'h0 || out_addr !== 3'd2) begin
            errors++;
            $display("FAIL stall_hold got %h/%0d expected 0/2", out_data, out_addr);
        end
        drain("stall");
        checks++;
        if (got_addr.size() != 3 || got_addr[0] != 2 || got_addr[1] != 3 || got_addr[2] != 4
            || got_data[0] != 0) begin
            errors++;
            $display("FAIL stall_beats got %0d beats expected addr 2,3,4 first data 0", got_addr.size());
        end
    endtask

    task automatic test_bypass_ignore();
        got_addr.delete(); got_data.delete();
        cycle(1'b1, 3'd5, 4'd4, 1'b1, 1'b1, 3'd5, 4'hA);
        checks++;
        if (out_data !== 4'hA) begin
            errors++;
            $display("FAIL bypass_data got %h expected a", out_data);
        end
        cycle(1'b1, 3'd0, 4'd2, 1'b1, 1'b0, '0, '0);
        drain("bypass");
        checks++;
        if (got_addr.size() != 4 || got_addr[0] != 5 || got_addr[3] != 0 || got_data[0] != 'hA) begin
            errors++;
            $display("FAIL ignore_start got %0d beats expected 4 beats addr 5..0", got_addr.size());
        end
    endtask

    task automatic test_len_zero_long();
        cycle(1'b1, 3'd3, 4'd0, 1'b1, 1'b0, '0, '0);
        checks++;
        if (rd_busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL len_zero busy/valid got %b%b expected 00", rd_busy, out_valid);
        end
        got_addr.delete(); got_data.delete();
        cycle(1'b1, 3'd0, 4'd15, 1'b1, 1'b0, '0, '0);
        drain("long");
        checks++;
        if (got_addr.size() != 15) begin
            errors++;
            $display("FAIL long_count got %0d expected 15", got_addr.size());
        end
        for (int i = 0; i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] != i % DEPTH || got_data[i] != int'(mem_m[i % DEPTH])) begin
                errors++;
                $display("FAIL long_beat%0d got %0d/%h expected %0d/%h", i, got_addr[i], got_data[i],
                         i % DEPTH, mem_m[i % DEPTH]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [ADDR_W-1:0] base;
            logic [ADDR_W:0]   len;
            base = ADDR_W'($urandom_range(DEPTH - 1, 0));
            len  = (ADDR_W + 1)'($urandom_range(15, 1));
            got_addr.delete(); got_data.delete();
            cycle(1'b1, base, len, 1'b1, 1'($urandom_range(1, 0)), ADDR_W'($urandom), WIDTH'($urandom));
            for (int i = 0; i < 200 && exp_valid; i++) begin
                cycle(1'($urandom_range(1, 0)), ADDR_W'($urandom), (ADDR_W + 1)'($urandom),
                      ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
                      ADDR_W'($urandom), WIDTH'($urandom));
            end
            checks++;
            if (exp_valid || got_addr.size() != int'(len)) begin
                errors++;
                $display("FAIL random%0d beats got %0d expected %0d", n, got_addr.size(), len);
            end
            for (int i = 0; i < got_addr.size(); i++) begin
                checks++;
                if (got_addr[i] != (int'(base) + i) % DEPTH) begin
                    errors++;
                    $display("FAIL random%0d addr%0d got %0d expected %0d", n, i, got_addr[i],
                             (int'(base) + i) % DEPTH);
                end
            end
            idle_cycle(1'b1);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, '0, 1'b1, 1'b1, ADDR_W'(i), WIDTH'(i + 3));
        cycle(1'b1, 3'd0, 4'd8, 1'b1, 1'b0, '0, '0);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, rd_busy, out_last, out_data, out_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset got %b%b%b %h %0d expected all 0",
                     out_valid, rd_busy, out_last, out_data, out_addr);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        got_addr.delete(); got_data.delete();
        cycle(1'b1, 3'd0, 4'd8, 1'b1, 1'b0, '0, '0);
        drain("post_reset");
        checks++;
        if (got_data.size() != 8 || got_data.sum() != 0) begin
            errors++;
            $display("FAIL post_reset_data got %0d beats sum %0d expected 8 beats sum 0",
                     got_data.size(), got_data.sum());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        idle_cycle(1'b1);
        test_wrap();
        test_stall();
        test_bypass_ignore();
        idle_cycle(1'b1);
        test_len_zero_long();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
